// File: rtl/ahb3lite_sram_slv.sv
// AHB3-Lite slave in front of a single-port SRAM: wait states, byte lanes, write-to-read forwarding, two-cycle ERROR.
// Optional feature macro: AHB3LITE_SRAM_SLV_SEQ_NOWAIT_EN (SEQ beats of non-SINGLE bursts become zero-wait).
module ahb3lite_sram_slv #(
  parameter int MEM_SIZE    = 4096,
  parameter int HADDR_SIZE  = 32,
  parameter int HDATA_SIZE  = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic                  HRESETn,
  input  logic                  HCLK,
  input  logic                  HSEL,
  input  logic [HADDR_SIZE-1:0] HADDR,
  input  logic [HDATA_SIZE-1:0] HWDATA,
  output logic [HDATA_SIZE-1:0] HRDATA,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  input  logic                  HMASTLOCK,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP
);
  localparam int BYTES  = HDATA_SIZE / 8;
  localparam int BL     = $clog2(BYTES);
  localparam int MEM_AW = $clog2(MEM_SIZE);
  localparam int WA     = MEM_AW - BL;
  localparam int WORDS  = MEM_SIZE / BYTES;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ERR1 = 2'd2;
  localparam logic [1:0] ST_ERR2 = 2'd3;

  logic [1:0]            state_reg;
  logic [3:0]            cnt_reg;
  logic                  ready;
  logic                  accept;
  logic                  rd_accept;
  logic                  legal;
  logic                  addr_oob;
  logic                  size_bad;
  logic                  misalign;
  logic                  seq_nowait;
  logic [7:0]            amask_full;
  logic [15:0]           be_full;
  logic [BYTES-1:0]      be;
  logic [WA-1:0]         word_addr;

  logic                  dp_read_reg;
  logic                  dp_write_reg;
  logic [WA-1:0]         dp_addr_reg;
  logic [BYTES-1:0]      dp_be_reg;
  logic                  wr_done;
  logic                  show_rd;

  logic                  wcommit_reg;
  logic [WA-1:0]         waddr_reg;
  logic [BYTES-1:0]      wbe_reg;
  logic [HDATA_SIZE-1:0] wdata_reg;

  logic [HDATA_SIZE-1:0] mem [0:WORDS-1];
  logic [HDATA_SIZE-1:0] mem_q_reg;

  logic                  dhit;
  logic                  chit;
  logic [BYTES-1:0]      fwd_be_reg;
  logic [BYTES-1:0]      fwd_be_next;
  logic [HDATA_SIZE-1:0] fwd_data_reg;
  logic [HDATA_SIZE-1:0] fwd_data_next;
  logic [HDATA_SIZE-1:0] rd_merged;
  logic [HDATA_SIZE-1:0] hold_reg;
  logic                  unused_sigs;

  assign ready     = (state_reg == ST_IDLE) || (state_reg == ST_ERR2);
  assign accept    = HSEL & HREADY & HTRANS[1] & ready;

  assign addr_oob   = |(HADDR >> MEM_AW);
  assign size_bad   = HSIZE > 3'(BL);
  assign amask_full = (8'd1 << HSIZE) - 8'd1;
  assign misalign   = |(HADDR[BL-1:0] & amask_full[BL-1:0]);
  assign legal      = !(addr_oob || size_bad || misalign);
  assign rd_accept  = accept && legal && !HWRITE;

  assign be_full   = ((16'd1 << (5'd1 << HSIZE)) - 16'd1) << HADDR[BL-1:0];
  assign be        = be_full[BYTES-1:0];
  assign word_addr = HADDR[MEM_AW-1:BL];

`ifdef AHB3LITE_SRAM_SLV_SEQ_NOWAIT_EN
  assign seq_nowait = (HTRANS == 2'b11) && (HBURST != 3'b000);
`else
  assign seq_nowait = 1'b0;
`endif

  assign unused_sigs = ^{HPROT, HMASTLOCK, HBURST, HTRANS, amask_full, be_full};

  assign HREADYOUT = (state_reg != ST_WAIT) && (state_reg != ST_ERR1);
  assign HRESP     = (state_reg == ST_ERR1) || (state_reg == ST_ERR2);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= 4'd0;
    end else begin
      case (state_reg)
        ST_IDLE, ST_ERR2: begin
          if (accept && !legal) begin
            state_reg <= ST_ERR1;
          end else if (accept && (WAIT_STATES > 0) && !seq_nowait) begin
            state_reg <= ST_WAIT;
            cnt_reg   <= 4'(WAIT_STATES);
          end else begin
            state_reg <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          cnt_reg <= cnt_reg - 4'd1;
          if (cnt_reg == 4'd1) state_reg <= ST_IDLE;
        end
        ST_ERR1: state_reg <= ST_ERR2;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // A data phase finishes on any edge where it sits in IDLE (HREADYOUT high).
  assign wr_done = dp_write_reg && (state_reg == ST_IDLE);
  assign show_rd = dp_read_reg && (state_reg == ST_IDLE);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_read_reg  <= 1'b0;
      dp_write_reg <= 1'b0;
      dp_addr_reg  <= '0;
      dp_be_reg    <= '0;
    end else if (accept) begin
      dp_read_reg  <= legal && !HWRITE;
      dp_write_reg <= legal && HWRITE;
      dp_addr_reg  <= word_addr;
      dp_be_reg    <= be;
    end else if (state_reg == ST_IDLE) begin
      dp_read_reg  <= 1'b0;
      dp_write_reg <= 1'b0;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wcommit_reg <= 1'b0;
      waddr_reg   <= '0;
      wbe_reg     <= '0;
      wdata_reg   <= '0;
    end else begin
      wcommit_reg <= wr_done;
      if (wr_done) begin
        waddr_reg <= dp_addr_reg;
        wbe_reg   <= dp_be_reg;
        wdata_reg <= HWDATA;
      end
    end
  end

  // Read and commit share the port; a same-edge read sees the old word and relies on forwarding.
  always_ff @(posedge HCLK) begin
    if (rd_accept) mem_q_reg <= mem[word_addr];
    if (wcommit_reg) begin
      for (int i = 0; i < BYTES; i++) begin
        if (wbe_reg[i]) mem[waddr_reg][i*8 +: 8] <= wdata_reg[i*8 +: 8];
      end
    end
  end

  assign dhit = wr_done && (dp_addr_reg == word_addr);
  assign chit = wcommit_reg && (waddr_reg == word_addr);

  // The write still in its data phase is younger than the one committing, so it wins per lane.
  generate
    for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
      assign fwd_be_next[gi] = (dhit && dp_be_reg[gi]) || (chit && wbe_reg[gi]);
      assign fwd_data_next[gi*8 +: 8] = (dhit && dp_be_reg[gi]) ? HWDATA[gi*8 +: 8]
                                                                : wdata_reg[gi*8 +: 8];
      assign rd_merged[gi*8 +: 8] = fwd_be_reg[gi] ? fwd_data_reg[gi*8 +: 8]
                                                   : mem_q_reg[gi*8 +: 8];
    end
  endgenerate

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      fwd_be_reg   <= '0;
      fwd_data_reg <= '0;
      hold_reg     <= '0;
    end else begin
      if (rd_accept) begin
        fwd_be_reg   <= fwd_be_next;
        fwd_data_reg <= fwd_data_next;
      end
      if (show_rd) hold_reg <= rd_merged;
    end
  end

  assign HRDATA = show_rd ? rd_merged : hold_reg;

endmodule

// File: tb/tb_ahb3lite_sram_slv.sv
// Randomized self-checking bench: two slaves (0 and 3 wait states) behind one bus mux, checked against a byte-array model.
module tb_ahb3lite_sram_slv;
  localparam int MEM_SIZE = 4096;
`ifdef AHB3LITE_SRAM_SLV_SEQ_NOWAIT_EN
  localparam bit NOWAIT_EN = 1'b1;
`else
  localparam bit NOWAIT_EN = 1'b0;
`endif

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [1:0]  trans;
    logic [2:0]  burst;
    logic [31:0] wdata;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hsel = 1'b0;
  logic [31:0] haddr = '0;
  logic [31:0] hwdata = '0;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = 3'd2;
  logic [2:0]  hburst = 3'd0;
  logic [3:0]  hprot = 4'b0011;
  logic [1:0]  htrans = 2'b00;
  logic        hmastlock = 1'b0;
  bit          sel = 1'b0;

  logic        sel0, sel3, ro0, ro3, rs0, rs3, bus_ready, bus_resp;
  logic [31:0] rd0, rd3, bus_rdata;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [7:0]  ref_mem [0:1][0:MEM_SIZE-1];
  logic [31:0] last_rd [0:1];
  txn_t        tq [$];

  assign sel0      = hsel & ~sel;
  assign sel3      = hsel & sel;
  assign bus_ready = sel ? ro3 : ro0;
  assign bus_resp  = sel ? rs3 : rs0;
  assign bus_rdata = sel ? rd3 : rd0;

  always #5 clk = ~clk;

  ahb3lite_sram_slv #(.MEM_SIZE(MEM_SIZE), .WAIT_STATES(0)) u_dut0 (
    .HRESETn(rst_n), .HCLK(clk), .HSEL(sel0), .HADDR(haddr), .HWDATA(hwdata),
    .HRDATA(rd0), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
    .HTRANS(htrans), .HMASTLOCK(hmastlock), .HREADY(bus_ready), .HREADYOUT(ro0), .HRESP(rs0)
  );

  ahb3lite_sram_slv #(.MEM_SIZE(MEM_SIZE), .WAIT_STATES(3)) u_dut3 (
    .HRESETn(rst_n), .HCLK(clk), .HSEL(sel3), .HADDR(haddr), .HWDATA(hwdata),
    .HRDATA(rd3), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
    .HTRANS(htrans), .HMASTLOCK(hmastlock), .HREADY(bus_ready), .HREADYOUT(ro3), .HRESP(rs3)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_legal(txn_t t);
    return (t.addr < MEM_SIZE) && (t.size <= 3'd2) && ((t.addr % (32'd1 << t.size)) == 0);
  endfunction

  function automatic logic [31:0] ref_word(int dut, logic [31:0] addr);
    int b;
    b = int'(addr) & ~3;
    return {ref_mem[dut][b+3], ref_mem[dut][b+2], ref_mem[dut][b+1], ref_mem[dut][b]};
  endfunction

  task automatic add(input logic wr, input logic [31:0] addr, input int size,
                     input logic [1:0] trans, input logic [2:0] burst, input logic [31:0] wdata);
    txn_t t;
    t.wr = wr; t.addr = addr; t.size = 3'(size); t.trans = trans; t.burst = burst; t.wdata = wdata;
    tq.push_back(t);
  endtask

  task automatic finish_txn(input int i, input int waits, input int rhi, input logic resp,
                            input logic [31:0] rdata);
    txn_t        t;
    bit          active, lg;
    int          exp_w, a;
    logic [31:0] exp_d;
    t      = tq[i];
    active = t.trans[1];
    lg     = is_legal(t);
    if (!active) exp_w = 0;
    else if (!lg) exp_w = 1;
    else if (NOWAIT_EN && t.trans == 2'b11 && t.burst != 3'b000) exp_w = 0;
    else exp_w = sel ? 3 : 0;
    check("waits", 64'(waits), 64'(exp_w));
    check("resp", 64'(resp), 64'(active && !lg));
    check("wait_resp", 64'(rhi), (active && !lg) ? 64'd1 : 64'd0);
    if (active && lg && !t.wr) begin
      exp_d = ref_word(int'(sel), t.addr);
      check("rdata", 64'(rdata), 64'(exp_d));
      last_rd[sel] = exp_d;
    end else begin
      check("hold", 64'(rdata), 64'(last_rd[sel]));
    end
    if (active && lg && t.wr) begin
      for (int k = 0; k < (1 << t.size); k++) begin
        a = int'(t.addr) + k;
        ref_mem[sel][a] = t.wdata[8*(a%4) +: 8];
      end
    end
    $display("dut%0d %s addr=%h size=%0d trans=%0d waits=%0d resp=%0b rdata=%h",
             sel ? 3 : 0, t.wr ? "WR" : "RD", t.addr, t.size, t.trans, waits, resp, rdata);
  endtask

  // Pipelined master: drives the next address phase while the previous data phase completes.
  task automatic run_seq();
    int          n, ap, dp, done, waits, rhi, cyc;
    logic        hr, rs;
    logic [31:0] rd;
    n = tq.size(); ap = 0; dp = -1; done = 0; waits = 0; rhi = 0; cyc = 0;
    while ((ap < n || dp >= 0) && cyc < 40 * n + 40) begin
      if (ap < n) begin
        hsel = 1'b1; haddr = tq[ap].addr; htrans = tq[ap].trans; hwrite = tq[ap].wr;
        hsize = tq[ap].size; hburst = tq[ap].burst;
      end else begin
        hsel = 1'b0; htrans = 2'b00;
      end
      hwdata = (dp >= 0 && tq[dp].wr) ? tq[dp].wdata : $urandom;
      @(negedge clk);
      hr = bus_ready; rs = bus_resp; rd = bus_rdata;
      if (dp >= 0) begin
        if (!hr) begin
          waits++;
          if (rs) rhi++;
        end else begin
          finish_txn(dp, waits, rhi, rs, rd);
          done++; waits = 0; rhi = 0;
        end
      end
      @(posedge clk); #1;
      cyc++;
      if (hr) begin
        dp = (ap < n) ? ap : -1;
        if (ap < n) ap++;
      end
    end
    check("drain", 64'(done), 64'(n));
    hsel = 1'b0; htrans = 2'b00;
    tq.delete();
  endtask

  task automatic init_region();
    for (int w = 0; w < 16; w++) add(1'b1, 32'(w * 4), 2, 2'b10, 3'd0, $urandom);
    run_seq();
  endtask

  task automatic rand_seq(input int n);
    int          k, sz;
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      k  = $urandom_range(0, 9);
      sz = (k == 0) ? 3 : $urandom_range(0, 2);
      a  = 32'($urandom_range(0, 63));
      if (k != 1) a = a & ~32'((1 << sz) - 1);
      if (k == 2) a = a | (32'h1000 << $urandom_range(0, 3));
      add(1'($urandom_range(0, 1)), a, sz,
          (k == 3) ? 2'($urandom_range(0, 1)) : ((i == 0) ? 2'b10 : 2'($urandom_range(2, 3))),
          3'($urandom_range(0, 7)), $urandom);
    end
    run_seq();
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      for (int a = 0; a < MEM_SIZE; a++) ref_mem[d][a] = 8'h00;
      last_rd[d] = 32'h0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready0", 64'(ro0), 64'd1);
    check("rst_resp0", 64'(rs0), 64'd0);
    check("rst_rdata0", 64'(rd0), 64'd0);
    check("rst_ready3", 64'(ro3), 64'd1);
    check("rst_resp3", 64'(rs3), 64'd0);
    check("rst_rdata3", 64'(rd3), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // zero-wait slave: forwarding, byte lanes, illegal transfers
    sel = 1'b0;
    init_region();
    add(1'b1, 32'h10, 2, 2'b10, 3'd0, 32'hDEAD_BEEF);
    add(1'b0, 32'h10, 2, 2'b10, 3'd0, 32'h0);
    add(1'b1, 32'h10, 2, 2'b10, 3'd0, 32'h1122_3344);
    add(1'b1, 32'h13, 0, 2'b10, 3'd0, 32'hAA5A_A5C3);
    add(1'b0, 32'h10, 2, 2'b10, 3'd0, 32'h0);
    add(1'b1, 32'h10, 1, 2'b10, 3'd0, 32'h7788_5566);
    add(1'b0, 32'h10, 2, 2'b10, 3'd0, 32'h0);
    run_seq();
    check("byte_half_word", 64'(last_rd[0]), 64'h0000_0000_AA22_5566);
    add(1'b0, 32'h1000, 2, 2'b10, 3'd0, 32'h0);
    add(1'b0, 32'h11, 1, 2'b10, 3'd0, 32'h0);
    add(1'b1, 32'h1000, 2, 2'b10, 3'd0, 32'h0BAD_0BAD);
    add(1'b1, 32'h11, 1, 2'b10, 3'd0, 32'h0BAD_0BAD);
    add(1'b0, 32'h10, 2, 2'b10, 3'd0, 32'h0);
    add(1'b0, 32'h00, 2, 2'b10, 3'd0, 32'h0);
    run_seq();
    rand_seq(60);

    // three-wait slave: single read, INCR4 burst, reset during a write's wait
    sel = 1'b1;
    init_region();
    add(1'b0, 32'h24, 2, 2'b10, 3'd0, 32'h0);
    run_seq();
    add(1'b0, 32'h30, 2, 2'b10, 3'd3, 32'h0);
    add(1'b0, 32'h34, 2, 2'b11, 3'd3, 32'h0);
    add(1'b0, 32'h38, 2, 2'b11, 3'd3, 32'h0);
    add(1'b0, 32'h3C, 2, 2'b11, 3'd3, 32'h0);
    run_seq();

    hsel = 1'b1; haddr = 32'h20; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2; hburst = 3'd0;
    @(posedge clk); #1;
    htrans = 2'b00; hwdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    check("wait_before_rst", 64'(ro3), 64'd0);
    rst_n = 1'b0;
    #1;
    check("rst_mid_ready", 64'(ro3), 64'd1);
    check("rst_mid_resp", 64'(rs3), 64'd0);
    check("rst_mid_rdata", 64'(rd3), 64'd0);
    hsel = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    last_rd[0] = 32'h0;
    last_rd[1] = 32'h0;
    add(1'b0, 32'h20, 2, 2'b10, 3'd0, 32'h0);
    run_seq();
    rand_seq(60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
